// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the arbiter / burst controller pair.
package arb_pkg;

    localparam int ARB_DATA_W = 8;
    localparam int ARB_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST0 = 2'd1,
        ST_BURST1 = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_beat_cnt.sv
// Loadable down-counter with zero flag; tracks beats remaining in a burst.
module arb_beat_cnt #(
    parameter int W = 4
) (
    input  logic         i_gclk,
    input  logic         i_grst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n)   r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/arb_burst_ctrl.sv
// Two-port fixed-length burst controller fed by the arbiter grants.
// Optional stall abort: define ARB_BURST_TIMEOUT_EN.
module arb_burst_ctrl
    import arb_pkg::*;
#(
    parameter int DATA_W  = ARB_DATA_W,
    parameter int LEN_W   = ARB_LEN_W,
    parameter int TIMEOUT = 15
) (
    input  logic              i_gclk,
    input  logic              i_grst_n,
    input  logic              i_gnt0,
    input  logic              i_gnt1,
    input  logic [LEN_W-1:0]  i_len0,
    input  logic [LEN_W-1:0]  i_len1,
    input  logic [DATA_W-1:0] i_d0,
    input  logic [DATA_W-1:0] i_d1,
    input  logic              i_v0,
    input  logic              i_v1,
    output logic              o_rdy0,
    output logic              o_rdy1,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_rdy,
    output logic              o_done0,
    output logic              o_done1,
    output logic              o_busy,
    output logic              o_err
);

    arb_state_e       r_state, w_next;
    logic             w_load, w_dec, w_beat, w_zero, w_tmo;
    logic [LEN_W-1:0] w_load_val;
    logic             r_done0, r_done1;

    arb_beat_cnt #(.W(LEN_W)) u_cnt (
        .i_gclk     (i_gclk),
        .i_grst_n   (i_grst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

`ifdef ARB_BURST_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    logic [SW-1:0] r_stall;
    logic          r_err;
    wire           w_in_burst = (r_state == ST_BURST0) || (r_state == ST_BURST1);

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n)                 r_stall <= '0;
        else if (!w_in_burst || w_beat) r_stall <= '0;
        else                           r_stall <= r_stall + 1'b1;
    end

    // Abort on the TIMEOUT-th consecutive stall cycle
    assign w_tmo = w_in_burst && !w_beat && (r_stall == STALL_LAST);

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) r_err <= 1'b0;
        else           r_err <= w_tmo;
    end
    assign o_err = r_err;
`else
    assign w_tmo = 1'b0;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        w_beat      = 1'b0;
        o_out_data  = '0;
        o_out_valid = 1'b0;
        o_rdy0      = 1'b0;
        o_rdy1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Port 0 wins if the arbiter ever asserts both grants
                if (i_gnt0) begin
                    w_load = 1'b1; w_load_val = i_len0; w_next = ST_BURST0;
                end else if (i_gnt1) begin
                    w_load = 1'b1; w_load_val = i_len1; w_next = ST_BURST1;
                end
            end
            ST_BURST0: begin
                o_out_data  = i_d0;
                o_out_valid = i_v0;
                o_rdy0      = i_out_rdy;
                w_beat      = i_v0 && i_out_rdy;
            end
            ST_BURST1: begin
                o_out_data  = i_d1;
                o_out_valid = i_v1;
                o_rdy1      = i_out_rdy;
                w_beat      = i_v1 && i_out_rdy;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_beat) begin
            if (w_zero) w_next = ST_GAP;
            else        w_dec  = 1'b1;
        end else if (w_tmo) begin
            w_next = ST_GAP;
        end
    end

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= (r_state == ST_BURST0) && w_beat && w_zero;
            r_done1 <= (r_state == ST_BURST1) && w_beat && w_zero;
        end
    end

    assign o_done0 = r_done0;
    assign o_done1 = r_done1;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// Directed bench for arb_burst_ctrl; timeout branch follows ARB_BURST_TIMEOUT_EN.
module tb_arb_burst_ctrl;

    logic       gclk = 1'b0;
    logic       grst_n;
    logic       gnt0, gnt1, v0, v1, out_rdy;
    logic [3:0] len0, len1;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, out_valid, done0, done1, busy, err;
    logic [7:0] out_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 gclk = ~gclk;

    arb_burst_ctrl dut (
        .i_gclk(gclk), .i_grst_n(grst_n),
        .i_gnt0(gnt0), .i_gnt1(gnt1),
        .i_len0(len0), .i_len1(len1),
        .i_d0(d0), .i_d1(d1), .i_v0(v0), .i_v1(v1),
        .o_rdy0(rdy0), .o_rdy1(rdy1),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_rdy(out_rdy),
        .o_done0(done0), .o_done1(done1), .o_busy(busy), .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        grst_n = 1'b0; gnt0 = 1'b1; gnt1 = 1'b0; v0 = 1'b1; v1 = 1'b0;
        out_rdy = 1'b1; len0 = 4'd3; len1 = 4'd0; d0 = 8'hA0; d1 = 8'h00;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_rdy0",  rdy0,      0);
        chk("rst_busy",  busy,      0);
        chk("rst_done0", done0,     0);
        chk("rst_err",   err,       0);

        // 4-beat burst on port 0
        grst_n = 1'b1;
        tick();
        chk("b0_busy", busy, 1);
        gnt0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d0 = 8'hA0 + 8'(i);
            settle();
            chk("b0_data",  out_data,  8'hA0 + i);
            chk("b0_valid", out_valid, 1);
            chk("b0_rdy0",  rdy0,      1);
            chk("b0_rdy1",  rdy1,      0);
            chk("b0_done0", done0,     0);
            tick();
        end
        chk("b0_gap_valid", out_valid, 0);
        chk("b0_gap_data",  out_data,  0);
        chk("b0_gap_done0", done0,     1);
        chk("b0_gap_busy",  busy,      1);
        tick();
        chk("b0_idle_busy",  busy,  0);
        chk("b0_idle_done0", done0, 0);

        // single beat on port 1 with a sink stall
        gnt1 = 1'b1; v1 = 1'b1; d1 = 8'h5B; out_rdy = 1'b0;
        tick();
        gnt1 = 1'b0;
        settle();
        chk("b1_stall_rdy1",  rdy1,      0);
        chk("b1_stall_valid", out_valid, 1);
        chk("b1_stall_data",  out_data,  8'h5B);
        tick();
        chk("b1_held_busy", busy, 1);
        out_rdy = 1'b1;
        settle();
        chk("b1_rdy1", rdy1, 1);
        chk("b1_rdy0", rdy0, 0);
        tick();
        chk("b1_done1", done1, 1);
        chk("b1_done0", done0, 0);
        tick();
        chk("b1_idle_done1", done1, 0);
        chk("b1_idle_busy",  busy,  0);

        // both grants: port 0 first, port 1 only after GAP
        gnt0 = 1'b1; gnt1 = 1'b1; len0 = 4'd1; len1 = 4'd2; d0 = 8'h11; d1 = 8'h22;
        tick();
        gnt0 = 1'b0;
        settle();
        chk("both_data0", out_data, 8'h11);
        chk("both_rdy1",  rdy1,     0);
        tick();
        chk("both_beat2", out_data, 8'h11);
        tick();
        chk("both_gap_done0", done0,     1);
        chk("both_gap_valid", out_valid, 0);
        chk("both_gap_rdy1",  rdy1,      0);
        tick();
        chk("both_idle_busy", busy, 0);
        tick();
        gnt1 = 1'b0;
        settle();
        chk("both_b1_data", out_data, 8'h22);
        chk("both_b1_rdy1", rdy1,     1);
        tick(); tick();
        chk("both_b1_last_done1", done1, 0);
        tick();
        chk("both_b1_done1", done1, 1);
        tick();

        // reset mid-burst, then fresh full burst
        gnt0 = 1'b1; len0 = 4'd3; d0 = 8'hC3;
        tick();
        gnt0 = 1'b0;
        tick(); tick();
        grst_n = 1'b0;
        settle();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy",  busy,      0);
        chk("mrst_rdy0",  rdy0,      0);
        chk("mrst_data",  out_data,  0);
        tick();
        chk("mrst_done0", done0, 0);
        grst_n = 1'b1; gnt0 = 1'b1;
        tick();
        gnt0 = 1'b0;
        tick(); tick(); tick();
        chk("fresh_beat4_busy",  busy,  1);
        chk("fresh_beat4_done0", done0, 0);
        tick();
        chk("fresh_done0", done0, 1);
        tick();

        // stall after first beat
        gnt0 = 1'b1; len0 = 4'd1; v0 = 1'b1;
        tick();
        gnt0 = 1'b0;
        tick();
        v0 = 1'b0;
`ifdef ARB_BURST_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            settle();
            chk("tmo_busy", busy, 1);
            chk("tmo_err",  err,  0);
            tick();
        end
        chk("tmo_err_pulse", err,       1);
        chk("tmo_no_done",   done0,     0);
        chk("tmo_gap_valid", out_valid, 0);
        tick();
        chk("tmo_idle_busy", busy, 0);
        chk("tmo_err_clr",   err,  0);
`else
        for (int i = 0; i < 20; i++) begin
            settle();
            chk("hold_busy",  busy,      1);
            chk("hold_valid", out_valid, 0);
            chk("hold_err",   err,       0);
            tick();
        end
        v0 = 1'b1;
        tick();
        chk("hold_done0", done0, 1);
        tick();
        chk("hold_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
